alu_mc: RTL and testbench

Multi-cycle, parametrised execute-stage ALU with a valid/ready handshake on both sides and a tag carried through for the reorder buffer. Add, sub, or, and, address generation, branch compare and jump pass-through complete in one cycle. MUL completes in a programmable number of cycles, during which the unit stalls issue. Unsupported encodings complete normally with a non-zero exception code, so the commit stage raises the trap.

---
 rtl/alu_mc_if.sv | 40 ++++
 rtl/alu_mc.sv | 190 +++++++++++++++++++
 tb/tb_alu_mc.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mc_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mc_if
//  Description : Request/response bundle for the multi-cycle execute ALU.
//                Request side (in_*): valid/ready, decode fields, operands
//                and tag. Response side (out_*): valid/ready, result,
//                operand-equality flag, exception code and tag.
//                master = issuing stage / consumer, slave = ALU.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_mc_if #(
    parameter int WORD_SIZE = 32,
    parameter int TAG_WIDTH = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [6:0]            opcode;
    logic [6:0]            funct7;
    logic [2:0]            funct3;
    logic [WORD_SIZE-1:0]  in_a;
    logic [WORD_SIZE-1:0]  in_b;
    logic [TAG_WIDTH-1:0]  in_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [WORD_SIZE-1:0]  out_result;
    logic                  out_zero;
    logic [WORD_SIZE-1:0]  out_exception;
    logic [TAG_WIDTH-1:0]  out_tag;

    modport master (
        output in_valid, opcode, funct7, funct3, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_exception, out_tag
    );

    modport slave (
        input  in_valid, opcode, funct7, funct3, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_exception, out_tag
    );
endinterface
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mc
//  Description : Execute-stage ALU. ADD/SUB/OR/AND, address generation,
//                branch compare and jump pass-through finish in one cycle;
//                MUL takes MUL_LATENCY cycles and stalls issue meanwhile.
//                Unsupported encodings complete with EXC_ILLEGAL.
//  Ports       : clk, rst (sync, active high), flush (drop in-flight op and
//                held result), bus (alu_mc_if.slave request/response).
//  Revision    : 1.0  initial release
// ============================================================================
module alu_mc #(
    parameter int                   WORD_SIZE   = 32,
    parameter int                   TAG_WIDTH   = 4,
    parameter int                   MUL_LATENCY = 5,
    parameter logic [WORD_SIZE-1:0] EXC_ILLEGAL = 1
) (
    input  wire logic  clk,
    input  wire logic  rst,
    input  wire logic  flush,
    alu_mc_if.slave    bus
);
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JUMP   = 7'b1101111;
    localparam int         CNT_W     = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_MUL_BUSY = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [WORD_SIZE-1:0]  mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [TAG_WIDTH-1:0]  mul_tag_q, mul_tag_d;
    logic                  mul_zero_q, mul_zero_d;
    logic                  out_valid_q, out_valid_d;
    logic [WORD_SIZE-1:0]  out_result_q, out_result_d;
    logic                  out_zero_q, out_zero_d;
    logic [WORD_SIZE-1:0]  out_exc_q, out_exc_d;
    logic [TAG_WIDTH-1:0]  out_tag_q, out_tag_d;

    logic                  w_in_ready;
    logic                  w_accept;
    logic [WORD_SIZE-1:0]  w_dec_result;
    logic                  w_dec_illegal;
    logic                  w_dec_mul;
    logic [WORD_SIZE-1:0]  w_mul_prod;

    // Low product bits are sign-agnostic, so a plain unsigned multiply suffices.
    assign w_mul_prod = mul_a_q * mul_b_q;

    assign w_in_ready = !rst && !flush && (state_q == S_IDLE) &&
                        (!out_valid_q || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    // Decode: illegal encodings leave the result at zero.
    always_comb begin
        w_dec_result  = '0;
        w_dec_illegal = 1'b0;
        w_dec_mul     = 1'b0;
        unique case (bus.opcode)
            OP_ALU: begin
                unique case (bus.funct7)
                    7'b0100000: w_dec_result = bus.in_a - bus.in_b;
                    7'b0000001: begin
                        w_dec_mul    = 1'b1;
                        w_dec_result = bus.in_a * bus.in_b;
                    end
                    7'b0000000: begin
                        unique case (bus.funct3)
                            3'b000:  w_dec_result = bus.in_a + bus.in_b;
                            3'b110:  w_dec_result = bus.in_a | bus.in_b;
                            3'b111:  w_dec_result = bus.in_a & bus.in_b;
                            default: w_dec_illegal = 1'b1;
                        endcase
                    end
                    default: w_dec_illegal = 1'b1;
                endcase
            end
            OP_IMM: begin
                if (bus.funct3 == 3'b000) w_dec_result  = bus.in_a + bus.in_b;
                else                      w_dec_illegal = 1'b1;
            end
            OP_LOAD, OP_STORE, OP_BRANCH: w_dec_result = bus.in_a + bus.in_b;
            OP_JUMP:                      w_dec_result = bus.in_a;
            default:                      w_dec_illegal = 1'b1;
        endcase
    end

    // Next-state and output-register logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        mul_tag_d    = mul_tag_q;
        mul_zero_d   = mul_zero_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_zero_d   = out_zero_q;
        out_exc_d    = out_exc_q;
        out_tag_d    = out_tag_q;

        if (flush) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_dec_mul && (MUL_LATENCY > 1)) begin
                            state_d    = S_MUL_BUSY;
                            cnt_d      = CNT_W'(MUL_LATENCY - 1);
                            mul_a_d    = bus.in_a;
                            mul_b_d    = bus.in_b;
                            mul_tag_d  = bus.in_tag;
                            mul_zero_d = (bus.in_a == bus.in_b);
                        end else begin
                            out_valid_d  = 1'b1;
                            out_result_d = w_dec_result;
                            out_zero_d   = (bus.in_a == bus.in_b);
                            out_exc_d    = w_dec_illegal ? EXC_ILLEGAL : '0;
                            out_tag_d    = bus.in_tag;
                        end
                    end
                end
                S_MUL_BUSY: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    // The counter reaches zero on the same edge that the
                    // product lands, giving exactly MUL_LATENCY cycles.
                    // The output register is empty here: acceptance needed it
                    // draining and nothing else could refill it.
                    if (cnt_q == CNT_W'(1)) begin
                        state_d      = S_IDLE;
                        out_valid_d  = 1'b1;
                        out_result_d = w_mul_prod;
                        out_zero_d   = mul_zero_q;
                        out_exc_d    = '0;
                        out_tag_d    = mul_tag_q;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            mul_tag_q    <= '0;
            mul_zero_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_zero_q   <= 1'b0;
            out_exc_q    <= '0;
            out_tag_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            mul_tag_q    <= mul_tag_d;
            mul_zero_q   <= mul_zero_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_zero_q   <= out_zero_d;
            out_exc_q    <= out_exc_d;
            out_tag_q    <= out_tag_d;
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_result    = out_result_q;
    assign bus.out_zero      = out_zero_q;
    assign bus.out_exception = out_exc_q;
    assign bus.out_tag       = out_tag_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_mc
//  Description : Scoreboard bench for alu_mc (WORD_SIZE 32, MUL_LATENCY 5).
//                Directed requests push hand-computed responses into a
//                queue; a monitor pops and compares on every transfer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_mc;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JUMP   = 7'b1101111;
    localparam logic [6:0] F7_ADD    = 7'b0000000;
    localparam logic [6:0] F7_SUB    = 7'b0100000;
    localparam logic [6:0] F7_MUL    = 7'b0000001;

    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic [31:0] exc;
        logic [3:0]  tag;
    } exp_t;

    logic clk;
    logic rst;
    logic flush;
    int   n_tests;
    int   n_fail;
    logic acc_out_valid;
    exp_t sb[$];

    alu_mc_if #(.WORD_SIZE(32), .TAG_WIDTH(4)) bus ();

    alu_mc #(
        .WORD_SIZE  (32),
        .TAG_WIDTH  (4),
        .MUL_LATENCY(5),
        .EXC_ILLEGAL(32'd1)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present a request from just after a rising edge, hold until accepted,
    // return with the bench 1ns past the accepting edge.
    task automatic issue(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                         input logic [31:0] eres, input logic [31:0] eexc,
                         input bit push, output int waits);
        exp_t e;
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.funct7   = f7;
        bus.funct3   = f3;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
        waits        = 0;
        @(negedge clk);
        while (!bus.in_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout tag=%0d: in_ready never rose, required 1", tag);
        end else if (push) begin
            e.res  = eres;
            e.zero = (a == b);
            e.exc  = eexc;
            e.tag  = tag;
            sb.push_back(e);
        end
        acc_out_valid = bus.out_valid;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic watch_quiet(input int cycles, input string name);
        logic seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check(name, 80'(seen), 80'd0);
    endtask

    // Monitor: every completed transfer must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_result: got tag %0h result %0h, required no output",
                             bus.out_tag, bus.out_result);
                end else begin
                    e = sb.pop_front();
                    if (bus.out_result !== e.res || bus.out_zero !== e.zero ||
                        bus.out_exception !== e.exc || bus.out_tag !== e.tag) begin
                        n_fail++;
                        $display("FAIL result_tag%0h: got res=%0h zero=%0b exc=%0h tag=%0h required res=%0h zero=%0b exc=%0h tag=%0h",
                                 e.tag, bus.out_result, bus.out_zero, bus.out_exception, bus.out_tag,
                                 e.res, e.zero, e.exc, e.tag);
                    end
                end
            end
        end
    end

    initial begin
        int w;
        n_tests       = 0;
        n_fail        = 0;
        acc_out_valid = 1'b0;
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.opcode    = OP_ALU;
        bus.funct7    = F7_ADD;
        bus.funct3    = 3'b000;
        bus.in_a      = 32'd9;
        bus.in_b      = 32'd9;
        bus.in_tag    = 4'hF;
        bus.out_ready = 1'b1;

        // Reset with a request pending: nothing accepted, outputs zero.
        repeat (3) begin
            @(negedge clk);
            check("reset_in_ready", 80'(bus.in_ready), 80'd0);
            check("reset_outputs",
                  80'({bus.out_valid, bus.out_result, bus.out_zero, bus.out_exception, bus.out_tag}),
                  80'd0);
        end
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", 80'(bus.in_ready), 80'd1);
        check("post_reset_out_valid", 80'(bus.out_valid), 80'd0);
        @(posedge clk);
        #1;

        // Back-to-back single-cycle ops.
        issue(OP_ALU, F7_ADD, 3'b000, 32'd5,   32'd7,   4'd1, 32'd12,       32'd0, 1, w);
        issue(OP_ALU, F7_SUB, 3'b000, 32'd3,   32'd5,   4'd2, 32'hFFFFFFFE, 32'd0, 1, w);
        check("b2b_sub_waits", 80'(w), 80'd0);
        issue(OP_ALU, F7_ADD, 3'b110, 32'hF0,  32'h0F,  4'd3, 32'hFF,       32'd0, 1, w);
        check("b2b_or_waits", 80'(w), 80'd0);
        issue(OP_ALU, F7_ADD, 3'b111, 32'hFF,  32'h3C,  4'd4, 32'h3C,       32'd0, 1, w);
        check("b2b_and_waits", 80'(w), 80'd0);
        issue(OP_BRANCH, 7'h00, 3'b000, 32'h55, 32'h55, 4'd5, 32'hAA,       32'd0, 1, w);
        issue(OP_JUMP,   7'h00, 3'b000, 32'h1234, 32'd0, 4'd12, 32'h1234,   32'd0, 1, w);
        issue(OP_LOAD,   7'h00, 3'b010, 32'h1000, 32'h10, 4'd13, 32'h1010,  32'd0, 1, w);
        issue(OP_STORE,  7'h00, 3'b010, 32'h20, 32'hFFFFFFFC, 4'd14, 32'h1C, 32'd0, 1, w);
        issue(OP_IMM,    7'h00, 3'b000, 32'd100, 32'd23, 4'd15, 32'd123,    32'd0, 1, w);

        // MUL then ADD: 4 stall cycles, product visible when ADD accepted.
        issue(OP_ALU, F7_MUL, 3'b000, 32'hFFFFFFFF, 32'd2, 4'd6, 32'hFFFFFFFE, 32'd0, 1, w);
        issue(OP_ALU, F7_ADD, 3'b000, 32'd1, 32'd1, 4'd7, 32'd2, 32'd0, 1, w);
        check("mul_stall_cycles", 80'(w), 80'd4);
        check("mul_valid_when_add_accepted", 80'(acc_out_valid), 80'd1);

        // Illegal encodings: result 0, exception 1, one-cycle latency.
        issue(7'b1111111, 7'h00, 3'b000, 32'd3, 32'd3, 4'd8, 32'd0, 32'd1, 1, w);
        check("illegal_b2b_waits", 80'(w), 80'd0);
        issue(OP_IMM, 7'h00, 3'b001, 32'd1, 32'd2, 4'd9, 32'd0, 32'd1, 1, w);
        check("illegal_imm_waits", 80'(w), 80'd0);
        issue(OP_ALU, F7_ADD, 3'b001, 32'd4, 32'd2, 4'd10, 32'd0, 32'd1, 1, w);
        check("illegal_alu_latency", 80'(acc_out_valid), 80'd1);

        // Backpressure: held result stable, no acceptance, then drain+accept.
        repeat (2) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        issue(OP_ALU, F7_ADD, 3'b000, 32'd10, 32'd20, 4'd8, 32'd30, 32'd0, 1, w);
        bus.in_valid = 1'b1;
        bus.opcode   = OP_ALU;
        bus.funct7   = F7_ADD;
        bus.funct3   = 3'b000;
        bus.in_a     = 32'd2;
        bus.in_b     = 32'd3;
        bus.in_tag   = 4'd9;
        repeat (4) begin
            @(negedge clk);
            check("hold_in_ready", 80'(bus.in_ready), 80'd0);
            check("hold_outputs",
                  80'({bus.out_valid, bus.out_result, bus.out_tag, bus.out_exception}),
                  80'({1'b1, 32'd30, 4'd8, 32'd0}));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        issue(OP_ALU, F7_ADD, 3'b000, 32'd2, 32'd3, 4'd9, 32'd5, 32'd0, 1, w);
        check("drain_accept_same_cycle", 80'(w), 80'd0);

        // Flush two cycles into a MUL.
        @(posedge clk);
        #1;
        issue(OP_ALU, F7_MUL, 3'b000, 32'd7, 32'd3, 4'd11, 32'd21, 32'd0, 0, w);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        check("flush_mul_in_ready", 80'(bus.in_ready), 80'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_mul_out_valid", 80'(bus.out_valid), 80'd0);
        check("flush_mul_in_ready_after", 80'(bus.in_ready), 80'd1);
        watch_quiet(8, "flush_mul_no_stale");

        // Flush while a result is held.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        issue(OP_ALU, F7_ADD, 3'b000, 32'd4, 32'd4, 4'd12, 32'd8, 32'd0, 0, w);
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("flush_hold_valid_before", 80'(bus.out_valid), 80'd1);
        check("flush_hold_in_ready", 80'(bus.in_ready), 80'd0);
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("flush_hold_out_valid", 80'(bus.out_valid), 80'd0);
        check("flush_hold_in_ready_after", 80'(bus.in_ready), 80'd1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        watch_quiet(4, "flush_hold_no_stale");

        // Reset in the middle of a MUL.
        @(posedge clk);
        #1;
        issue(OP_ALU, F7_MUL, 3'b000, 32'd6, 32'd6, 4'd13, 32'd36, 32'd0, 0, w);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mul_outputs",
              80'({bus.out_valid, bus.out_result, bus.out_zero, bus.out_exception, bus.out_tag}),
              80'd0);
        check("rst_mul_in_ready", 80'(bus.in_ready), 80'd1);
        watch_quiet(8, "rst_mul_no_stale");

        // Everything pushed must have been seen.
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_empty", 80'(sb.size()), 80'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
